// File: rtl/shift_seq8_pkg.sv
// rtl/shift_seq8_pkg.sv - shared widths, op codes and FSM states for the sequential shifter
package shift_seq8_pkg;

  localparam int WIDTH = 8;
  localparam int SHW   = 3;
  localparam int STEP  = 3;

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift8_step.sv
// rtl/shift8_step.sv - combinational 0..3 position shift for LSL/LSR/ASR/ROR
module shift8_step
  import shift_seq8_pkg::*;
(
  input  logic [WIDTH-1:0] d_i,
  input  logic [1:0]       op_i,
  input  logic [1:0]       amt_i,
  output logic [WIDTH-1:0] y_o
);

  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d,
                                                input logic [1:0]       op,
                                                input logic [1:0]       k);
    logic [2*WIDTH-1:0] wide;
    wide = '0;
    case (op)
      OP_LSL:  wide = {{WIDTH{1'b0}}, d << k};
      OP_LSR:  wide = {{WIDTH{1'b0}}, d} >> k;
      OP_ASR:  wide = {{WIDTH{d[WIDTH-1]}}, d} >> k;
      default: wide = {d, d} >> k;
    endcase
    return wide[WIDTH-1:0];
  endfunction

  // One candidate per amount, selected by amt_i: a 4-to-1 mux on every bit.
  always_comb begin
    y_o = d_i;
    case (amt_i)
      2'd0:    y_o = shift_by(d_i, op_i, 2'd0);
      2'd1:    y_o = shift_by(d_i, op_i, 2'd1);
      2'd2:    y_o = shift_by(d_i, op_i, 2'd2);
      default: y_o = shift_by(d_i, op_i, 2'd3);
    endcase
  end

endmodule

// File: rtl/shift_seq8.sv
// rtl/shift_seq8.sv - multi-cycle 8-bit shift engine issuing steps of at most 3 positions
module shift_seq8
  import shift_seq8_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] d_in,
  input  logic [SHW-1:0]   shamt,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d_out
);

  state_t           state_q;
  logic [WIDTH-1:0] data_q;
  logic [SHW-1:0]   rem_q;
  logic [1:0]       opr_q;

  logic [1:0]       step_amt;
  logic [SHW-1:0]   rem_next_d;
  logic [WIDTH-1:0] shifted_d;

  assign step_amt   = (rem_q > SHW'(STEP)) ? 2'(STEP) : rem_q[1:0];
  assign rem_next_d = rem_q - {{(SHW-2){1'b0}}, step_amt};

  shift8_step u_step (
    .d_i   (data_q),
    .op_i  (opr_q),
    .amt_i (step_amt),
    .y_o   (shifted_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      rem_q   <= '0;
      opr_q   <= OP_LSL;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            data_q  <= d_in;
            opr_q   <= op;
            rem_q   <= shamt;
            state_q <= (shamt != '0) ? ST_SHIFT : ST_DONE;
          end
        end
        ST_SHIFT: begin
          data_q <= shifted_d;
          rem_q  <= rem_next_d;
          if (rem_next_d == '0) state_q <= ST_DONE;
        end
        ST_DONE: begin
          // No bypass: a new request can only be taken once back in IDLE.
          if (out_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign d_out     = data_q;

endmodule
